fetch_pc_unit: RTL and testbench

- Instruction-fetch stage of the MIPS core. Owns the PC, issues requests to instruction memory over a req/ready handshake, and loads the IF/ID register.
- Consumes the 32-bit sign-extended immediate produced in decode to compute branch targets, and the 26-bit jump field to compute jump targets.
- Handles decode stalls with a one-entry hold buffer.
- Handles branch/jump redirects, including a drain of an in-flight memory request.

---
 rtl/fetch_pc_unit.sv | 130 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ready handshake,
// buffers one word across decode stalls and drains stale requests after redirects.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_pc4,
   input  logic [31:0] signedimm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] drain_addr, drain_addr_n;
   logic [31:0] hold_buf, hold_buf_n;
   logic [31:0] instr_n, pc4_n;
   logic        valid_n;

   logic        redirect;
   logic [31:0] br_sum;
   logic [31:0] j_target;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = branch_taken | jump;
   assign br_sum   = branch_pc4 + (signedimm << 2);
   assign j_target = {branch_pc4[31:28], jump_index, 2'b00};
   // Branch wins over jump; low bits masked so the PC stays word-aligned.
   assign target   = (branch_taken ? br_sum : j_target) & 32'hFFFF_FFFC;
   assign pc_plus4 = pc + 32'd4;

   // Request is held off while reset is asserted even though the state reads REQ.
   assign imem_req  = !rst && (state != HOLD);
   assign imem_addr = (state == DRAIN) ? drain_addr : pc;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      hold_buf_n   = hold_buf;
      instr_n      = if_id_instr;
      pc4_n        = if_id_pc4;
      valid_n      = if_id_valid;

      if (redirect) begin
         pc_n       = target;
         valid_n    = 1'b0;
         hold_buf_n = '0;
         if (state == HOLD || imem_ready) begin
            state_n = REQ;
         end else begin
            state_n = DRAIN;
            // Remember the address still owed by memory; a DRAIN re-redirect keeps it.
            if (state == REQ) drain_addr_n = pc;
         end
      end else begin
         unique case (state)
            REQ: begin
               if (imem_ready) begin
                  if (!stall) begin
                     instr_n = imem_rdata;
                     pc4_n   = pc_plus4;
                     valid_n = 1'b1;
                     pc_n    = pc_plus4;
                  end else begin
                     hold_buf_n = imem_rdata;
                     state_n    = HOLD;
                  end
               end else if (!stall) begin
                  valid_n = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_n = hold_buf;
                  pc4_n   = pc_plus4;
                  valid_n = 1'b1;
                  pc_n    = pc_plus4;
                  state_n = REQ;
               end
            end
            DRAIN: begin
               valid_n = 1'b0;
               if (imem_ready) state_n = REQ;
            end
            default: begin
               state_n = REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= REQ;
         pc          <= RESET_PC;
         drain_addr  <= '0;
         hold_buf    <= '0;
         if_id_instr <= '0;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         drain_addr  <= drain_addr_n;
         hold_buf    <= hold_buf_n;
         if_id_instr <= instr_n;
         if_id_pc4   <= pc4_n;
         if_id_valid <= valid_n;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit; memory returns address + 0x1000_0000.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_pc4;
   logic [31:0] signedimm;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_pc4   (branch_pc4),
      .signedimm    (signedimm),
      .jump         (jump),
      .jump_index   (jump_index),
      .if_id_instr  (if_id_instr),
      .if_id_pc4    (if_id_pc4),
      .if_id_valid  (if_id_valid)
   );

   assign imem_rdata = imem_addr + 32'h1000_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        rdy;
      logic        stl;
      logic        br;
      logic        jmp;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [25:0] jidx;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_valid;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rdy, input logic stl, input logic br, input logic jmp,
                      input logic [31:0] pc4, input logic [31:0] imm, input logic [25:0] jidx,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
      vec_t v;
      v.rdy = rdy; v.stl = stl; v.br = br; v.jmp = jmp;
      v.pc4 = pc4; v.imm = imm; v.jidx = jidx;
      v.e_req = e_req; v.e_addr = e_addr;
      v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      imem_ready   = v.rdy;
      stall        = v.stl;
      branch_taken = v.br;
      jump         = v.jmp;
      branch_pc4   = v.pc4;
      signedimm    = v.imm;
      jump_index   = v.jidx;
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      jump = 1'b0; branch_pc4 = '0; signedimm = '0; jump_index = '0;

      //   rdy stl br jmp  pc4           imm           jidx    | req addr          instr         pc4           v
      // zero-wait streaming
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h0,        32'h1000_0000, 32'h4,        1);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h4,        32'h1000_0004, 32'h8,        1);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h8,        32'h1000_0008, 32'hC,        1);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'hC,        32'h1000_000C, 32'h10,       1);
      // stall for 3 cycles starting on an accepted fetch at 0x10
      add(1, 1, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h10,       32'h1000_000C, 32'h10,       1);
      add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,  0, 32'h10,       32'h1000_000C, 32'h10,       1);
      add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,  0, 32'h10,       32'h1000_000C, 32'h10,       1);
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  0, 32'h10,       32'h1000_0010, 32'h14,       1);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h14,       32'h1000_0014, 32'h18,       1);
      // ready every third cycle
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h18,       32'h1000_0014, 32'h18,       0);
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h18,       32'h1000_0014, 32'h18,       0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h18,       32'h1000_0018, 32'h1C,       1);
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h1C,       32'h1000_0018, 32'h1C,       0);
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h1C,       32'h1000_0018, 32'h1C,       0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h1C,       32'h1000_001C, 32'h20,       1);
      // wait plus stall keeps IF/ID valid
      add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h20,       32'h1000_001C, 32'h20,       1);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h20,       32'h1000_0020, 32'h24,       1);
      // backward branch, then wrapping forward branch
      add(1, 0, 1, 0, 32'h100,      32'hFFFF_FFFE, 26'h0,  1, 32'h24,       32'h1000_0020, 32'h24,       0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'hF8,       32'h1000_00F8, 32'hFC,       1);
      add(1, 0, 1, 0, 32'hFFFF_FFF0, 32'h7FFF,    26'h0,  1, 32'hFC,       32'h1000_00F8, 32'hFC,       0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h1_FFEC,   32'h1001_FFEC, 32'h1_FFF0,   1);
      // jump, then jump and branch together
      add(1, 0, 0, 1, 32'h4000_0010, 32'h0,       26'h40, 1, 32'h1_FFF0,   32'h1001_FFEC, 32'h1_FFF0,   0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h4000_0100, 32'h5000_0100, 32'h4000_0104, 1);
      add(1, 0, 1, 1, 32'h4000_0010, 32'h4,       26'h40, 1, 32'h4000_0104, 32'h5000_0100, 32'h4000_0104, 0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h4000_0020, 32'h5000_0020, 32'h4000_0024, 1);
      // redirect while waiting: drain old address, re-redirect inside drain
      add(0, 0, 1, 0, 32'h200,      32'h10,       26'h0,  1, 32'h4000_0024, 32'h5000_0020, 32'h4000_0024, 0);
      add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h4000_0024, 32'h5000_0020, 32'h4000_0024, 0);
      add(0, 0, 1, 0, 32'h300,      32'h0,        26'h0,  1, 32'h4000_0024, 32'h5000_0020, 32'h4000_0024, 0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h4000_0024, 32'h5000_0020, 32'h4000_0024, 0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h300,      32'h1000_0300, 32'h304,      1);
      // redirect out of HOLD goes straight to REQ
      add(1, 1, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h304,      32'h1000_0300, 32'h304,      1);
      add(0, 1, 0, 1, 32'h500,      32'h0,        26'h10, 0, 32'h304,      32'h1000_0300, 32'h304,      0);
      add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h40,       32'h1000_0040, 32'h44,       1);
      // park in HOLD for the reset sequence below
      add(1, 1, 0, 0, 32'h0,        32'h0,        26'h0,  1, 32'h44,       32'h1000_0040, 32'h44,       1);

      #1;
      chk("rst req",   {31'b0, imem_req},    32'h0);
      chk("rst addr",  imem_addr,            32'h0);
      chk("rst instr", if_id_instr,          32'h0);
      chk("rst pc4",   if_id_pc4,            32'h0);
      chk("rst valid", {31'b0, if_id_valid}, 32'h0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
         chk($sformatf("v%0d addr", i),  imem_addr,         tbl[i].e_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d instr", i), if_id_instr,          tbl[i].e_instr);
         chk($sformatf("v%0d pc4", i),   if_id_pc4,            tbl[i].e_pc4);
         chk($sformatf("v%0d valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
         @(negedge clk);
      end

      // reset pulsed mid-HOLD clears outputs without waiting for a clock edge
      imem_ready = 1'b0; stall = 1'b1; branch_taken = 1'b0; jump = 1'b0;
      rst = 1'b1;
      #1;
      chk("hold rst req",   {31'b0, imem_req},    32'h0);
      chk("hold rst addr",  imem_addr,            32'h0);
      chk("hold rst instr", if_id_instr,          32'h0);
      chk("hold rst pc4",   if_id_pc4,            32'h0);
      chk("hold rst valid", {31'b0, if_id_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; imem_ready = 1'b1;
      #1;
      chk("restart req",  {31'b0, imem_req}, 32'h1);
      chk("restart addr", imem_addr,         32'h0);
      @(posedge clk);
      #1;
      chk("restart instr", if_id_instr,          32'h1000_0000);
      chk("restart pc4",   if_id_pc4,            32'h4);
      chk("restart valid", {31'b0, if_id_valid}, 32'h1);
      @(negedge clk);
      chk("restart next addr", imem_addr, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
